pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the 16-bit core. It holds the architectural PC, issues instruction-memory reads, and steps the PC by 2 per fetched instruction using a pc_incr sub-module. It accepts branch/jump redirects from execute and presents fetched instructions to decode through a one-entry valid/ready output register.

## Interface
- PC_W, 16, PC and address width
- INSTR_W, 16, instruction width
- RESET_VECTOR, 16'h0000, PC value after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- stall  in  1  blocks issue of new fetches
- halt_req  in  1  request to enter HALT
- redirect_valid  in  1  load redirect_target into PC, flush
- redirect_target  in  PC_W  branch/jump target
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address
- imem_ready  in  1  memory accept; transfer = imem_req & imem_ready, data on imem_rdata same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- if_valid  out  1  output register holds an instruction
- if_instr  out  INSTR_W  fetched instruction
- if_pc  out  PC_W  address of if_instr
- if_ready  in  1  decode accepts; handshake = if_valid & if_ready
- halted  out  1  high in HALT
- align_err  out  1  misaligned redirect pulse

## Operation
- States: BOOT, IDLE, BUSY, HALT. Reset enters BOOT.
- free = !if_valid | if_ready.
- BOOT: one cycle, → IDLE.
- IDLE: halt_req → HALT; else if !stall → BUSY; else stay.
- BUSY: imem_addr = pc (stable throughout BUSY); imem_req = free. On transfer: if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc + 2; then halt_req → HALT, stall → IDLE, else stay BUSY (back-to-back fetch).
- Once in BUSY, stall does not cancel the pending request; it only prevents the next one.
- Output handshake without a new transfer clears if_valid.
- HALT: no requests; halted = 1; if_valid retained until consumed; halt_req low → IDLE.
- redirect_valid has priority in BOOT/IDLE/BUSY: pc <= target, if_valid <= 0, → IDLE; a same-cycle transfer is discarded. In HALT: pc <= target, stay HALT, if_valid untouched.
- PC arithmetic modulo 2^PC_W: 16'hFFFE + 2 = 16'h0000, no flag.

## Timing
- Reset values: pc = RESET_VECTOR, imem_req = 0, imem_addr = RESET_VECTOR, if_valid = 0, if_instr = 0, if_pc = 0, halted = 0, align_err = 0.
- First imem_req at the second rising edge after rst_n deasserts (BOOT, IDLE, then BUSY).
- Fetch latency: transfer in cycle N → if_valid/if_instr at N+1.
- Sustained throughput: one instruction per cycle with imem_ready = 1, if_ready = 1, stall = 0.
- Redirect at N: pc = target at N+1 (IDLE); imem_req with imem_addr = target at N+2.
- Reset mid-transfer: all state cleared immediately, no response captured.

## Configuration
- PC_FETCH_ALIGN_CHECK_EN defined: a redirect target with bit 0 set loads target & ~1 into pc, and align_err is high for exactly the following cycle.
- Undefined: target loaded verbatim; align_err is tied 0 (port always present).

## Structure
- Shared package: state encoding (BOOT/IDLE/BUSY/HALT), PC_W, INSTR_W, RESET_VECTOR default, PC step constant (2).
- One sub-module: pc_incr (combinational pc + 2, PC_W wide); everything else lives in pc_fetch_unit.

## Test plan
- Reset release, imem_ready = 1, if_ready = 1 → imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles; if_pc follows one cycle later.
- if_ready = 0 for 3 cycles while if_valid = 1 → imem_req low, imem_addr frozen, if_instr unchanged; fetch resumes the cycle if_ready rises.
- Redirect to 0x1234 in BUSY with a same-cycle transfer → data discarded, if_valid 0, next imem_addr 0x1234.
- pc = 0xFFFE fetched → next imem_addr 0x0000.
- halt_req during BUSY → current transfer completes, halted = 1, no further imem_req; halt_req low → fetch restarts at next PC.
- With PC_FETCH_ALIGN_CHECK_EN, redirect to 0x0101 → imem_addr 0x0100, align_err single-cycle pulse.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch unit: state encoding, default widths,
// reset vector and PC step.
package pc_fetch_unit_pkg;

  localparam int unsigned          PC_W_DEFAULT         = 16;
  localparam int unsigned          INSTR_W_DEFAULT      = 16;
  localparam logic [15:0]          RESET_VECTOR_DEFAULT = 16'h0000;
  localparam int unsigned          PC_STEP              = 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_incr.sv
// Combinational PC stepper: pc + PC_STEP, wrapping modulo 2^PC_W.
import pc_fetch_unit_pkg::*;

module pc_incr #(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  assign pc_next = pc + PC_W'(PC_STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer with a one-entry valid/ready output register.
// Optional macro PC_FETCH_ALIGN_CHECK_EN: force redirect targets even and pulse align_err.
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
  parameter int unsigned    PC_W         = PC_W_DEFAULT,
  parameter int unsigned    INSTR_W      = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready,
  output logic               halted,
  output logic               align_err
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus;
  logic [PC_W-1:0] redir_pc;
  logic            free;
  logic            transfer;

  pc_incr #(.PC_W(PC_W)) u_pc_incr (
    .pc      (pc),
    .pc_next (pc_plus)
  );

  assign free      = !if_valid || if_ready;
  assign imem_req  = (state == ST_BUSY) && free;
  assign imem_addr = pc;
  assign transfer  = imem_req && imem_ready;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic align_q;
  assign redir_pc  = {redirect_target[PC_W-1:1], 1'b0};
  assign align_err = align_q;
`else
  assign redir_pc  = redirect_target;
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_VECTOR;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
      align_q  <= 1'b0;
`endif
    end else begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
      align_q <= redirect_valid && redirect_target[0];
`endif
      // A consumed entry empties unless a transfer below refills it.
      if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end

      if (state == ST_HALT) begin
        if (redirect_valid) begin
          pc <= redir_pc;
        end
        if (!halt_req) begin
          state  <= ST_IDLE;
          halted <= 1'b0;
        end
      end else if (redirect_valid) begin
        // Redirect flushes the output register and drops any same-cycle transfer.
        pc       <= redir_pc;
        if_valid <= 1'b0;
        state    <= ST_IDLE;
        halted   <= 1'b0;
      end else begin
        unique case (state)
          ST_BOOT: begin
            state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (halt_req) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (!stall) begin
              state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (transfer) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc_plus;
              if (halt_req) begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end else if (stall) begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; memory returns addr ^ 16'hA5A5.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt_req;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic        halted;
  logic        align_err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 16'hA5A5;

  pc_fetch_unit #(
    .PC_W         (16),
    .INSTR_W      (16),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_ready        (if_ready),
    .halted          (halted),
    .align_err       (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_target = 16'h0000; imem_ready = 1'b1; if_ready = 1'b1;
    go(); go();
    chk("rst_req",    32'(imem_req),  32'h0);
    chk("rst_addr",   32'(imem_addr), 32'h0000);
    chk("rst_valid",  32'(if_valid),  32'h0);
    chk("rst_instr",  32'(if_instr),  32'h0000);
    chk("rst_pc",     32'(if_pc),     32'h0000);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_align",  32'(align_err), 32'h0);

    rst_n = 1'b1; #1;
    chk("boot_req", 32'(imem_req), 32'h0);
    go();
    chk("idle_req", 32'(imem_req), 32'h0);
    go();
    chk("f0_req",  32'(imem_req),  32'h1);
    chk("f0_addr", 32'(imem_addr), 32'h0000);
    go();
    chk("f1_addr",  32'(imem_addr), 32'h0002);
    chk("f1_valid", 32'(if_valid),  32'h1);
    chk("f1_ifpc",  32'(if_pc),     32'h0000);
    chk("f1_instr", 32'(if_instr),  32'hA5A5);
    go();
    chk("f2_addr",  32'(imem_addr), 32'h0004);
    chk("f2_ifpc",  32'(if_pc),     32'h0002);
    chk("f2_instr", 32'(if_instr),  32'hA5A7);

    // Backpressure for three cycles
    if_ready = 1'b0; #1;
    chk("bp_req0",  32'(imem_req),  32'h0);
    chk("bp_addr0", 32'(imem_addr), 32'h0004);
    for (int i = 0; i < 3; i++) begin
      go();
      chk("bp_req",   32'(imem_req),  32'h0);
      chk("bp_addr",  32'(imem_addr), 32'h0004);
      chk("bp_instr", 32'(if_instr),  32'hA5A7);
      chk("bp_valid", 32'(if_valid),  32'h1);
    end
    if_ready = 1'b1; #1;
    chk("resume_req",  32'(imem_req),  32'h1);
    chk("resume_addr", 32'(imem_addr), 32'h0004);
    go();
    chk("f3_addr",  32'(imem_addr), 32'h0006);
    chk("f3_ifpc",  32'(if_pc),     32'h0004);
    chk("f3_instr", 32'(if_instr),  32'hA5A1);

    // Redirect with a same-cycle transfer
    redirect_valid = 1'b1; redirect_target = 16'h1234;
    go();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(if_valid),  32'h0);
    chk("rd_req",   32'(imem_req),  32'h0);
    chk("rd_addr",  32'(imem_addr), 32'h1234);
    chk("rd_ifpc",  32'(if_pc),     32'h0004);
    go();
    chk("rd_req2",  32'(imem_req),  32'h1);
    chk("rd_addr2", 32'(imem_addr), 32'h1234);
    go();
    chk("rd_ifpc3",  32'(if_pc),     32'h1234);
    chk("rd_instr3", 32'(if_instr),  32'hB791);
    chk("rd_addr3",  32'(imem_addr), 32'h1236);

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_target = 16'hFFFE;
    go();
    redirect_valid = 1'b0;
    chk("wr_addr0", 32'(imem_addr), 32'hFFFE);
    go();
    chk("wr_req1",  32'(imem_req),  32'h1);
    go();
    chk("wr_addr2",  32'(imem_addr), 32'h0000);
    chk("wr_ifpc2",  32'(if_pc),     32'hFFFE);
    chk("wr_instr2", 32'(if_instr),  32'h5A5B);
    go();
    chk("wr_addr3", 32'(imem_addr), 32'h0002);
    chk("wr_ifpc3", 32'(if_pc),     32'h0000);

    // Halt during BUSY: pending transfer completes first
    halt_req = 1'b1;
    go();
    chk("h_halted", 32'(halted),   32'h1);
    chk("h_req",    32'(imem_req), 32'h0);
    chk("h_ifpc",   32'(if_pc),    32'h0002);
    chk("h_valid",  32'(if_valid), 32'h1);
    go();
    chk("h_halted2", 32'(halted),   32'h1);
    chk("h_req2",    32'(imem_req), 32'h0);
    chk("h_valid2",  32'(if_valid), 32'h0);
    go();
    chk("h_req3", 32'(imem_req), 32'h0);
    halt_req = 1'b0;
    go();
    chk("h_exit_halted", 32'(halted),   32'h0);
    chk("h_exit_req",    32'(imem_req), 32'h0);
    go();
    chk("h_restart_req",  32'(imem_req),  32'h1);
    chk("h_restart_addr", 32'(imem_addr), 32'h0004);

    // Odd redirect target
    redirect_valid = 1'b1; redirect_target = 16'h0101;
    go();
    redirect_valid = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chk("al_addr",  32'(imem_addr), 32'h0100);
    chk("al_pulse", 32'(align_err), 32'h1);
    go();
    chk("al_pulse_end", 32'(align_err), 32'h0);
    chk("al_addr2",     32'(imem_addr), 32'h0100);
`else
    chk("al_addr",  32'(imem_addr), 32'h0101);
    chk("al_pulse", 32'(align_err), 32'h0);
    go();
    chk("al_pulse_end", 32'(align_err), 32'h0);
    chk("al_addr2",     32'(imem_addr), 32'h0101);
`endif
    chk("al_req2", 32'(imem_req), 32'h1);

    // Asynchronous reset while a request is outstanding
    rst_n = 1'b0; #1;
    chk("ar_req",   32'(imem_req),  32'h0);
    chk("ar_addr",  32'(imem_addr), 32'h0000);
    chk("ar_valid", 32'(if_valid),  32'h0);
    chk("ar_ifpc",  32'(if_pc),     32'h0000);
    go();
    chk("ar_hold_valid", 32'(if_valid), 32'h0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
